// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: reset PC and the
// occupancy states, encoded as {skid_v, main_v}.
package pipe_pkg;

  localparam logic [31:0] PC_RST_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_OVER  = 2'b11
  } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One entry register (valid, pc, ctrl, data). Clear drops only the valid
// bit; pc and data keep their last value so a flush never disturbs them.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int              DATA_W = 64,
  parameter int              CTRL_W = 8,
  parameter int              PC_W   = 32,
  parameter logic [PC_W-1:0] PC_RST = PC_W'(PC_RST_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [PC_W-1:0]   pc_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= PC_RST;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage with optional skid slot, flush and
// a saturating back-pressure counter.
//   state    | meaning
//   EMPTY    | no entry held, outputs idle
//   FULL     | main slot holds the head entry
//   OVER     | main and skid both hold entries, in_ready low (SKID=1 only)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W = 64,
  parameter int              CTRL_W = 8,
  parameter int              PC_W   = 32,
  parameter logic [PC_W-1:0] PC_RST = PC_W'(PC_RST_DEFAULT),
  parameter bit              SKID   = 1'b1,
  parameter int              CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_v, skid_v;
  logic [PC_W-1:0]   main_pc, skid_pc, main_pc_in;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;
  logic              main_load, main_clr, main_from_skid, skid_load, skid_clr;
  logic              accept, issue;
  pipe_state_e       state;
  logic [CNT_W-1:0]  stall_q, stall_d;

  assign accept = in_valid & in_ready & ~flush;
  assign issue  = main_v & out_ready;
  assign state  = pipe_state_e'({skid_v, main_v});

  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: main_load = accept;
        ST_FULL: begin
          if (accept && issue) main_load = 1'b1;
          else if (accept)     skid_load = 1'b1;
          else if (issue)      main_clr  = 1'b1;
        end
        ST_OVER: begin
          if (issue) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          // skid without main cannot be reached; recover to EMPTY
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_pc_in   = main_from_skid ? skid_pc   : in_pc;
  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_in = main_from_skid ? skid_data : in_data;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .PC_W(PC_W), .PC_RST(PC_RST)) u_main (
    .clk(clk), .rst_n(reset), .load_i(main_load), .clear_i(main_clr),
    .pc_i(main_pc_in), .ctrl_i(main_ctrl_in), .data_i(main_data_in),
    .valid_o(main_v), .pc_o(main_pc), .ctrl_o(main_ctrl), .data_o(main_data)
  );

  if (SKID) begin : g_skid
    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .PC_W(PC_W), .PC_RST(PC_RST)) u_skid (
      .clk(clk), .rst_n(reset), .load_i(skid_load), .clear_i(skid_clr),
      .pc_i(in_pc), .ctrl_i(in_ctrl), .data_i(in_data),
      .valid_o(skid_v), .pc_o(skid_pc), .ctrl_o(skid_ctrl), .data_o(skid_data)
    );
    // registered ready: no path from out_ready
    assign in_ready = ~skid_v;
  end else begin : g_single
    assign skid_v    = 1'b0;
    assign skid_pc   = '0;
    assign skid_ctrl = '0;
    assign skid_data = '0;
    assign in_ready  = ~main_v | out_ready;
  end

  assign stall_d = (main_v && !out_ready && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign out_valid = main_v;
  assign out_pc    = main_pc;
  assign out_ctrl  = main_v ? main_ctrl : '0;
  assign out_data  = main_data;
  assign stall_cnt = stall_q;

endmodule
